// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply / restoring divide engine for the HI/LO path.
// One op per start; result lands in hi/lo with a one-cycle done pulse.
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic               op_div;
    logic               neg_main;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   low;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last;

    assign mag_a = (signed_op && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b = (signed_op && in_b[WIDTH-1]) ? -in_b : in_b;
    assign last  = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy from accept edge through the FIX cycle
    always_comb begin
        busy = (state != IDLE);
    end

    // Iteration arithmetic and final sign correction
    always_comb begin
        add_sum  = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        trial    = {acc, low[WIDTH-1]} - {1'b0, opnd};
        prod     = {acc, low};
        prod_fix = neg_main ? -prod : prod;
        quo_fix  = neg_main ? -low : low;
        rem_fix  = neg_rem ? -acc : acc;
    end

    // Datapath: operand capture, iterations, result load
    // acc/low serve as {acc,mplr} for multiply and {rem,quotient} for divide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            op_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            b_zero      <= 1'b0;
            raw_a       <= '0;
            opnd        <= '0;
            acc         <= '0;
            low         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_div   <= mul0_div1_sel;
                        neg_main <= signed_op & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        neg_rem  <= signed_op & in_a[WIDTH-1];
                        b_zero   <= (in_b == '0);
                        raw_a    <= in_a;
                        opnd     <= mul0_div1_sel ? mag_b : mag_a;
                        low      <= mul0_div1_sel ? mag_a : mag_b;
                        acc      <= '0;
                        count    <= '0;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (!op_div) begin
                        acc <= add_sum[WIDTH:1];
                        low <= {add_sum[0], low[WIDTH-1:1]};
                    end else if (!trial[WIDTH]) begin
                        acc <= trial[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {acc[WIDTH-2:0], low[WIDTH-1]};
                        low <= {low[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!op_div) begin
                        hi          <= prod_fix[2*WIDTH-1:WIDTH];
                        lo          <= prod_fix[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end else if (b_zero) begin
                        hi          <= raw_a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi          <= rem_fix;
                        lo          <= quo_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: arithmetic reference model plus directed
// vectors with hand-computed literal results.
module tb_muldiv_iter_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sel;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    muldiv_iter_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mul0_div1_sel(sel),
        .signed_op    (sgn),
        .in_a         (a),
        .in_b         (b),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (dbz),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {dbz, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_op(input logic d, input logic s,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        longint      sx;
        longint      sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!d) begin
            if (s) p = sx * sy;
            else p = {32'd0, x} * {32'd0, y};
            return {1'b0, p};
        end
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (s) begin
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = {32'd0, x / y};
            r = {32'd0, x % y};
        end
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Cycle model: op completes WIDTH+1 edges after acceptance
    logic        m_busy;
    logic        m_done;
    logic        m_dbz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [64:0] m_pend;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dbz  <= m_pend[64];
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 33;
                m_pend <= ref_op(sel, sgn, a, b);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy || done !== m_done || dbz !== m_dbz ||
            hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL model t=%0t got busy=%b done=%b dbz=%b hi=%h lo=%h want busy=%b done=%b dbz=%b hi=%h lo=%h",
                     $time, busy, done, dbz, hi, lo,
                     m_busy, m_done, m_dbz, m_hi, m_lo);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic d, input logic s,
                         input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        sel   = d;
        sgn   = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles", nm, done, cyc);
        end
    endtask

    task automatic run_op(input string nm, input logic d, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
        int cyc;
        issue(d, s, x, y);
        wait_done(nm, cyc);
        chk({nm, "_lat"}, 64'(cyc), 64'd33);
        chk({nm, "_hi"}, 64'(hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo), 64'(elo));
        chk({nm, "_dbz"}, 64'(dbz), 64'(edbz));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sel    = 1'b0;
        sgn    = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        run_op("umul_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("smul", 0, 1, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("udiv", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("sdiv", 1, 1, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("sdiv_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 0);
        run_op("div0", 1, 0, 32'h0000_1234, 32'd0,
               32'h0000_1234, 32'hFFFF_FFFF, 1);
        run_op("after_div0", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("sdiv0", 1, 1, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        run_op("umul_mix", 0, 0, 32'h0001_0000, 32'h0003_0000,
               32'h0000_0003, 32'h0000_0000, 0);

        // Starts while busy must be ignored
        issue(1, 0, 32'd1000, 32'd3);
        chk("busy_after_accept", 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 5 || cyc == 20) begin
                start = 1'b1;
                sel   = 1'b0;
                sgn   = 1'b1;
                a     = 32'hDEAD_BEEF;
                b     = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("ignore_lat", 64'(cyc), 64'd33);
        chk("ignore_hi", 64'(hi), 64'd1);
        chk("ignore_lo", 64'(lo), 64'd333);

        // Start coincident with done is accepted without a gap
        start = 1'b1;
        sel   = 1'b0;
        sgn   = 1'b0;
        a     = 32'd6;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b", cyc);
        chk("b2b_lat", 64'(cyc), 64'd33);
        chk("b2b_res", {hi, lo}, 64'd42);

        // Async reset mid-CALC aborts the op
        issue(0, 0, 32'h0000_0005, 32'h0000_0009);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("arst_no_done", 64'(seen), 64'd0);

        run_op("post_rst", 1, 1, 32'd50, 32'hFFFF_FFF9,
               32'd1, 32'hFFFF_FFF9, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
